// File: rtl/bcd_converter.sv
// Sequential 16-bit binary to 4-digit BCD converter using shift-and-add-3 (double dabble).
// Values above 9999 saturate the display value to 9999 and raise overflow.
module bcd_converter (
  input  logic        clk_100mhz,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_out,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [19:0] acc_q, acc_d;
  logic [19:0] acc_adj;
  logic [4:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_100mhz) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == 5'd15) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: correct each digit before the shift so it cannot exceed 9 afterwards.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      acc_adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3
                                                     : acc_q[4*i +: 4];
    end
    sr_d   = sr_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    bcd_d  = bcd_q;
    ovf_d  = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d  = bin_in;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      SHIFT: begin
        acc_d = {acc_adj[18:0], sr_q[15]};
        sr_d  = {sr_q[14:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
      end
      FINISH: begin
        done_d = 1'b1;
        if (acc_q[19:16] != 4'd0) begin
          bcd_d = 16'h9999;
          ovf_d = 1'b1;
        end else begin
          bcd_d = acc_q[15:0];
          ovf_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      sr_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      bcd_q  <= bcd_d;
      ovf_q  <= ovf_d;
    end
  end

  // Output logic: busy covers SHIFT and FINISH; result outputs come straight from flops.
  always_comb begin
    busy     = (state_q != IDLE);
    done     = done_q;
    bcd_out  = bcd_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_bcd_converter.sv
// Directed self-checking bench for bcd_converter: latency, saturation, ignored starts,
// back-to-back conversions and reset abort.
module tb_bcd_converter;

  logic        clk_100mhz = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  bcd_converter dut (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .start      (start),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .bcd_out    (bcd_out),
    .overflow   (overflow)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents start/bin_in for one edge; returns at the negedge after the accepting edge.
  task automatic do_start(input logic [15:0] value);
    @(negedge clk_100mhz);
    start  = 1'b1;
    bin_in = value;
    @(negedge clk_100mhz);
    start  = 1'b0;
  endtask

  // Steps one edge at a time until done; n counts edges since the accepting edge.
  // busy_ok reports busy high before done; held reports bcd_out unchanged before done.
  task automatic wait_done(input int n0, output int n, output bit busy_ok, output bit held);
    logic [15:0] entry_bcd;
    entry_bcd = bcd_out;
    n       = n0;
    busy_ok = 1'b1;
    held    = 1'b1;
    do begin
      @(negedge clk_100mhz);
      n++;
      if (!done && !busy) busy_ok = 1'b0;
      if (!done && bcd_out !== entry_bcd) held = 1'b0;
    end while (!done && n < 40);
  endtask

  // Counts done pulses over a window of idle cycles.
  task automatic count_dones(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_100mhz);
      if (done) pulses++;
    end
  endtask

  task automatic convert(input string tag, input logic [15:0] value,
                         input logic [15:0] exp_bcd, input logic exp_ovf);
    int n;
    bit busy_ok, held;
    do_start(value);
    check({tag, "_busy_on_accept"}, busy, 1'b1);
    wait_done(0, n, busy_ok, held);
    check({tag, "_latency"}, n, 17);
    check({tag, "_busy_during"}, busy_ok, 1'b1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_bcd"}, bcd_out, exp_bcd);
    check({tag, "_ovf"}, overflow, exp_ovf);
    @(negedge clk_100mhz);
    check({tag, "_done_one_cycle"}, done, 1'b0);
    check({tag, "_bcd_hold"}, bcd_out, exp_bcd);
  endtask

  initial begin
    int n, pulses;
    bit busy_ok, held;

    // Reset, with start held high to confirm reset priority.
    reset  = 1'b1;
    start  = 1'b1;
    bin_in = 16'd1234;
    repeat (3) @(negedge clk_100mhz);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bcd", bcd_out, 16'h0000);
    check("rst_ovf", overflow, 1'b0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk_100mhz);
    check("idle_busy", busy, 1'b0);

    convert("zero", 16'd0, 16'h0000, 1'b0);
    convert("v1234", 16'd1234, 16'h1234, 1'b0);
    convert("v9999", 16'd9999, 16'h9999, 1'b0);
    convert("v10000", 16'd10000, 16'h9999, 1'b1);
    convert("v65535", 16'd65535, 16'h9999, 1'b1);
    convert("v0_after_ovf", 16'd5, 16'h0005, 1'b0);

    // Start pulse and bin_in changes during busy are ignored.
    do_start(16'd42);
    @(negedge clk_100mhz);
    start  = 1'b1;
    bin_in = 16'd77;
    @(negedge clk_100mhz);
    start  = 1'b0;
    bin_in = 16'd1111;
    wait_done(2, n, busy_ok, held);
    check("ign_latency", n, 17);
    check("ign_bcd", bcd_out, 16'h0042);
    count_dones(25, pulses);
    check("ign_no_second_done", pulses, 0);
    check("ign_idle", busy, 1'b0);

    // Back-to-back: second start presented in the done cycle.
    do_start(16'd500);
    wait_done(0, n, busy_ok, held);
    check("b2b_first_latency", n, 17);
    check("b2b_first_bcd", bcd_out, 16'h0500);
    start  = 1'b1;
    bin_in = 16'd7;
    @(negedge clk_100mhz);
    start  = 1'b0;
    check("b2b_accepted", busy, 1'b1);
    check("b2b_done_low", done, 1'b0);
    wait_done(0, n, busy_ok, held);
    check("b2b_period", n + 1, 18);
    check("b2b_held", held, 1'b1);
    check("b2b_bcd", bcd_out, 16'h0007);

    // Reset five cycles into a conversion aborts it.
    do_start(16'd8888);
    repeat (4) @(negedge clk_100mhz);
    reset = 1'b1;
    @(negedge clk_100mhz);
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_bcd", bcd_out, 16'h0000);
    check("abort_ovf", overflow, 1'b0);
    count_dones(25, pulses);
    check("abort_no_done", pulses, 0);
    convert("after_abort", 16'd31, 16'h0031, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
